// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl -- round sequencer for the number-guessing game.
//
// Runs the game flow from decoded keypad strobes to win/lose. It collects
// a 4-digit secret, then collects 4-digit guesses. It triggers and samples
// the external A/B matcher, holds each result for display, counts attempts
// and declares WIN or LOSE.
//
// Ports:
//   clk        system clock (divided keypad clock domain)
//   rst        asynchronous active-high reset
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   0-9 digit, 10 enter, 11 backspace, 12 restart, 13-15 ignored
//   r_a, r_b   matcher A/B counts for (secret, guess)
//   entry      digits being typed, 4 BCD nibbles, newest in [3:0]
//   entry_cnt  number of digits currently in entry (0..4)
//   secret     committed secret, to matcher
//   guess      committed guess, to matcher
//   match_en   high for the whole CHECK phase
//   last_a/b   sampled matcher result of the latest guess
//   tries      completed attempts
//   phase      0 SET_SECRET, 1 GUESS, 2 CHECK, 3 RESULT, 4 WIN, 5 LOSE
//   dup_err    one-cycle pulse when a duplicate digit is rejected
//   win, lose  phase == WIN / phase == LOSE
module guess_round_ctrl #(
    parameter int MAX_TRIES   = 10,
    parameter int MATCH_LAT   = 0,
    parameter int RESULT_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [2:0]  r_a,
    input  logic [2:0]  r_b,
    output logic [15:0] entry,
    output logic [2:0]  entry_cnt,
    output logic [15:0] secret,
    output logic [15:0] guess,
    output logic        match_en,
    output logic [2:0]  last_a,
    output logic [2:0]  last_b,
    output logic [3:0]  tries,
    output logic [2:0]  phase,
    output logic        dup_err,
    output logic        win,
    output logic        lose
);

    typedef enum logic [2:0] {
        PH_SET_SECRET = 3'd0,
        PH_GUESS      = 3'd1,
        PH_CHECK      = 3'd2,
        PH_RESULT     = 3'd3,
        PH_WIN        = 3'd4,
        PH_LOSE       = 3'd5
    } phase_t;

    // One counter serves both CHECK (matcher latency) and RESULT (display
    // hold); the two phases never overlap.
    localparam int CNT_MAX = (MATCH_LAT > RESULT_HOLD) ? MATCH_LAT : RESULT_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(MATCH_LAT);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESULT_HOLD - 1);
    localparam logic [3:0]       TRIES_LIMIT = 4'(MAX_TRIES);

    phase_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [15:0]       entry_n, secret_n, guess_n;
    logic [2:0]        entry_cnt_n, last_a_n, last_b_n;
    logic [3:0]        tries_n, tries_inc;
    logic              dup_n;
    logic              is_digit, is_enter, is_back, is_restart, present;

    assign is_digit   = key_valid && (key_code <= 4'd9);
    assign is_enter   = key_valid && (key_code == 4'd10);
    assign is_back    = key_valid && (key_code == 4'd11);
    assign is_restart = key_valid && (key_code == 4'd12);
    assign tries_inc  = tries + 4'd1;

    // Only the occupied nibbles take part in the duplicate test; empty
    // nibbles are zero and would otherwise falsely match digit 0.
    always_comb begin
        present = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < entry_cnt) && (entry[i*4 +: 4] == key_code)) begin
                present = 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        entry_n     = entry;
        entry_cnt_n = entry_cnt;
        secret_n    = secret;
        guess_n     = guess;
        last_a_n    = last_a;
        last_b_n    = last_b;
        tries_n     = tries;
        dup_n       = 1'b0;

        if (is_restart) begin
            state_n     = PH_SET_SECRET;
            cnt_n       = '0;
            entry_n     = '0;
            entry_cnt_n = '0;
            secret_n    = '0;
            guess_n     = '0;
            last_a_n    = '0;
            last_b_n    = '0;
            tries_n     = '0;
        end else begin
            case (state)
                PH_SET_SECRET, PH_GUESS: begin
                    if (is_digit && (entry_cnt < 3'd4)) begin
                        if (present) begin
                            dup_n = 1'b1;
                        end else begin
                            entry_n     = {entry[11:0], key_code};
                            entry_cnt_n = entry_cnt + 3'd1;
                        end
                    end else if (is_back && (entry_cnt != 3'd0)) begin
                        entry_n     = {4'h0, entry[15:4]};
                        entry_cnt_n = entry_cnt - 3'd1;
                    end else if (is_enter && (entry_cnt == 3'd4)) begin
                        if (state == PH_SET_SECRET) begin
                            secret_n = entry;
                            state_n  = PH_GUESS;
                        end else begin
                            guess_n  = entry;
                            state_n  = PH_CHECK;
                        end
                        entry_n     = '0;
                        entry_cnt_n = '0;
                        cnt_n       = '0;
                    end
                end
                PH_CHECK: begin
                    if (cnt == CHECK_LAST) begin
                        last_a_n = r_a;
                        last_b_n = r_b;
                        tries_n  = tries_inc;
                        cnt_n    = '0;
                        // A correct final guess wins rather than loses.
                        if (r_a == 3'd4) begin
                            state_n = PH_WIN;
                        end else if (tries_inc == TRIES_LIMIT) begin
                            state_n = PH_LOSE;
                        end else begin
                            state_n = PH_RESULT;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                PH_RESULT: begin
                    if (cnt == HOLD_LAST) begin
                        state_n = PH_GUESS;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PH_SET_SECRET;
            cnt       <= '0;
            entry     <= '0;
            entry_cnt <= '0;
            secret    <= '0;
            guess     <= '0;
            last_a    <= '0;
            last_b    <= '0;
            tries     <= '0;
            dup_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            entry     <= entry_n;
            entry_cnt <= entry_cnt_n;
            secret    <= secret_n;
            guess     <= guess_n;
            last_a    <= last_a_n;
            last_b    <= last_b_n;
            tries     <= tries_n;
            dup_err   <= dup_n;
        end
    end

    assign phase    = state;
    assign match_en = (state == PH_CHECK);
    assign win      = (state == PH_WIN);
    assign lose     = (state == PH_LOSE);

endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb_guess_round_ctrl -- self-checking bench for guess_round_ctrl.
//
// Directed scenario tasks, followed by a randomized key session. The
// session is compared every cycle against a queue-based game model. The
// matcher inputs are driven from the true A/B score of the model's
// secret and guess.
module tb_guess_round_ctrl;

    localparam int MAX_TRIES   = 3;
    localparam int MATCH_LAT   = 2;
    localparam int RESULT_HOLD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [2:0]  r_a, r_b;
    logic [15:0] entry, secret, guess;
    logic [2:0]  entry_cnt, last_a, last_b, phase;
    logic [3:0]  tries;
    logic        match_en, dup_err, win, lose;

    int n_checks = 0;
    int n_pass   = 0;

    guess_round_ctrl #(
        .MAX_TRIES  (MAX_TRIES),
        .MATCH_LAT  (MATCH_LAT),
        .RESULT_HOLD(RESULT_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .r_a      (r_a),
        .r_b      (r_b),
        .entry    (entry),
        .entry_cnt(entry_cnt),
        .secret   (secret),
        .guess    (guess),
        .match_en (match_en),
        .last_a   (last_a),
        .last_b   (last_b),
        .tries    (tries),
        .phase    (phase),
        .dup_err  (dup_err),
        .win      (win),
        .lose     (lose)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_phase;
    int          m_q[$];      // typed digits, oldest first
    logic [15:0] m_secret, m_guess;
    int          m_tries, m_a, m_b, m_cnt;
    bit          m_dup;

    task automatic m_reset();
        m_phase = 0; m_q.delete(); m_secret = '0; m_guess = '0;
        m_tries = 0; m_a = 0; m_b = 0; m_cnt = 0; m_dup = 0;
    endtask

    function automatic logic [15:0] m_entry();
        int v = 0;
        foreach (m_q[i]) v = v * 16 + m_q[i];
        return 16'(v);
    endfunction

    function automatic void calc_ab(input logic [15:0] s, input logic [15:0] g,
                                    output int a, output int b);
        a = 0; b = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (s[i*4 +: 4] == g[j*4 +: 4]) begin
                    if (i == j) a++; else b++;
                end
    endfunction

    task automatic model_step(input logic kv, input logic [3:0] kc,
                              input logic [2:0] ra, input logic [2:0] rb);
        int d;
        bit found;
        d = int'(kc);
        m_dup = 0;
        if (kv && d == 12) begin
            m_reset();
            return;
        end
        case (m_phase)
            0, 1: if (kv) begin
                if (d <= 9) begin
                    if (m_q.size() < 4) begin
                        found = 0;
                        foreach (m_q[i]) if (m_q[i] == d) found = 1;
                        if (found) m_dup = 1; else m_q.push_back(d);
                    end
                end else if (d == 11) begin
                    if (m_q.size() > 0) void'(m_q.pop_back());
                end else if (d == 10 && m_q.size() == 4) begin
                    if (m_phase == 0) begin m_secret = m_entry(); m_phase = 1; end
                    else begin m_guess = m_entry(); m_phase = 2; end
                    m_q.delete();
                    m_cnt = 0;
                end
            end
            2: begin
                m_cnt++;
                if (m_cnt == MATCH_LAT + 1) begin
                    m_a = int'(ra); m_b = int'(rb); m_tries++; m_cnt = 0;
                    if (ra == 3'd4) m_phase = 4;
                    else if (m_tries == MAX_TRIES) m_phase = 5;
                    else m_phase = 3;
                end
            end
            3: begin
                m_cnt++;
                if (m_cnt == RESULT_HOLD) begin m_phase = 1; m_cnt = 0; end
            end
            default: ;
        endcase
    endtask

    // One clock: drive at negedge, model at posedge, outputs settled at +1.
    task automatic step(input logic kv, input logic [3:0] kc);
        int a, b;
        @(negedge clk);
        calc_ab(m_secret, m_guess, a, b);
        key_valid = kv;
        key_code  = kc;
        r_a = 3'(a > 7 ? 7 : a);
        r_b = 3'(b > 7 ? 7 : b);
        @(posedge clk);
        model_step(kv, kc, r_a, r_b);
        #1;
    endtask

    task automatic type_word(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) step(1'b1, w[i*4 +: 4]);
        step(1'b1, 4'd10);
    endtask

    task automatic wait_leave_check();
        int n = 0;
        while (phase == 3'd2 && n < 20) begin step(1'b0, 4'd0); n++; end
        if (phase == 3'd2) begin
            n_checks++;
            $display("FAIL check_timeout: phase=%0d still CHECK after %0d cycles", phase, n);
        end
    endtask

    task automatic wait_phase(input logic [2:0] target);
        int n = 0;
        while (phase !== target && n < 40) begin step(1'b0, 4'd0); n++; end
        if (phase !== target) begin
            n_checks++;
            $display("FAIL wait_phase_timeout: phase=%0d required %0d", phase, target);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        key_valid = 0; key_code = 0; r_a = 0; r_b = 0;
        rst = 0;
        #1 rst = 1;
        #2;
        n_checks++;
        if ({entry, entry_cnt, secret, guess, match_en, last_a, last_b, tries, phase, dup_err, win, lose} !== 68'h0)
            $display("FAIL reset_async: outputs=%h required 0",
                     {entry, entry_cnt, secret, guess, match_en, last_a, last_b, tries, phase, dup_err, win, lose});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (phase !== 3'd0 || tries !== 4'd0) $display("FAIL reset_held: phase=%0d tries=%0d required 0/0", phase, tries);
        else n_pass++;
        @(negedge clk);
        rst = 0;
        m_reset();
    endtask

    task automatic test_secret();
        type_word(16'h1234);
        n_checks++;
        if (secret !== 16'h1234) $display("FAIL secret_commit: secret=%h required 1234", secret); else n_pass++;
        n_checks++;
        if (phase !== 3'd1 || entry !== 16'h0 || entry_cnt !== 3'd0 || tries !== 4'd0)
            $display("FAIL secret_phase: phase=%0d entry=%h cnt=%0d tries=%0d required 1/0000/0/0", phase, entry, entry_cnt, tries);
        else n_pass++;
    endtask

    task automatic test_edit();
        step(1'b1, 4'd5);
        step(1'b1, 4'd6);
        n_checks++;
        if (dup_err !== 1'b0) $display("FAIL dup_early: dup_err=%b required 0", dup_err); else n_pass++;
        step(1'b1, 4'd5);
        n_checks++;
        if (entry !== 16'h0056 || entry_cnt !== 3'd2 || dup_err !== 1'b1)
            $display("FAIL dup_digit: entry=%h cnt=%0d dup=%b required 0056/2/1", entry, entry_cnt, dup_err);
        else n_pass++;
        step(1'b0, 4'd0);
        n_checks++;
        if (dup_err !== 1'b0) $display("FAIL dup_pulse: dup_err=%b required 0", dup_err); else n_pass++;
        step(1'b1, 4'd11);
        n_checks++;
        if (entry !== 16'h0005 || entry_cnt !== 3'd1)
            $display("FAIL backspace: entry=%h cnt=%0d required 0005/1", entry, entry_cnt);
        else n_pass++;
        step(1'b1, 4'd10);
        n_checks++;
        if (phase !== 3'd1 || entry !== 16'h0005) $display("FAIL short_enter: phase=%0d entry=%h required 1/0005", phase, entry);
        else n_pass++;
        step(1'b1, 4'd11);
        step(1'b1, 4'd11);
        step(1'b1, 4'd14);
        n_checks++;
        if (entry !== 16'h0 || entry_cnt !== 3'd0) $display("FAIL empty_backspace: entry=%h cnt=%0d required 0/0", entry, entry_cnt);
        else n_pass++;
        for (int d = 1; d <= 4; d++) step(1'b1, 4'(d));
        step(1'b1, 4'd7);
        n_checks++;
        if (entry !== 16'h1234 || entry_cnt !== 3'd4 || dup_err !== 1'b0)
            $display("FAIL full_digit: entry=%h cnt=%0d dup=%b required 1234/4/0", entry, entry_cnt, dup_err);
        else n_pass++;
        step(1'b1, 4'd1);
        n_checks++;
        if (dup_err !== 1'b0 || entry !== 16'h1234) $display("FAIL full_dup: dup=%b entry=%h required 0/1234", dup_err, entry);
        else n_pass++;
        repeat (4) step(1'b1, 4'd11);
    endtask

    task automatic test_check();
        int n_en, n_res;
        type_word(16'h1243);
        n_en = (match_en === 1'b1) ? 1 : 0;
        while (match_en === 1'b1 && n_en < 20) begin
            step(1'b0, 4'd0);
            if (match_en === 1'b1) n_en++;
        end
        n_checks++;
        if (n_en != MATCH_LAT + 1) $display("FAIL match_en_len: cycles=%0d required %0d", n_en, MATCH_LAT + 1); else n_pass++;
        n_checks++;
        if (last_a !== 3'd2 || last_b !== 3'd2 || tries !== 4'd1 || phase !== 3'd3)
            $display("FAIL check_result: a=%0d b=%0d tries=%0d phase=%0d required 2/2/1/3", last_a, last_b, tries, phase);
        else n_pass++;
        n_res = (phase === 3'd3) ? 1 : 0;
        while (phase === 3'd3 && n_res < 40) begin
            step(1'b1, 4'd9);
            if (phase === 3'd3) n_res++;
        end
        n_checks++;
        if (n_res != RESULT_HOLD || phase !== 3'd1 || entry !== 16'h0)
            $display("FAIL result_hold: cycles=%0d phase=%0d entry=%h required %0d/1/0000", n_res, phase, entry, RESULT_HOLD);
        else n_pass++;
    endtask

    task automatic test_win();
        type_word(16'h5678);
        wait_leave_check();
        wait_phase(3'd1);
        type_word(16'h1234);
        wait_leave_check();
        n_checks++;
        if (phase !== 3'd4 || win !== 1'b1 || lose !== 1'b0 || tries !== 4'd3)
            $display("FAIL win_final: phase=%0d win=%b lose=%b tries=%0d required 4/1/0/3", phase, win, lose, tries);
        else n_pass++;
        n_checks++;
        if (guess !== 16'h1234 || last_a !== 3'd4 || last_b !== 3'd0)
            $display("FAIL win_display: guess=%h a=%0d b=%0d required 1234/4/0", guess, last_a, last_b);
        else n_pass++;
        step(1'b1, 4'd5);
        step(1'b1, 4'd10);
        step(1'b1, 4'd11);
        n_checks++;
        if (phase !== 3'd4 || entry !== 16'h0 || entry_cnt !== 3'd0 || guess !== 16'h1234)
            $display("FAIL win_terminal: phase=%0d entry=%h cnt=%0d guess=%h required 4/0000/0/1234", phase, entry, entry_cnt, guess);
        else n_pass++;
        step(1'b1, 4'd12);
        n_checks++;
        if ({entry, entry_cnt, secret, guess, match_en, last_a, last_b, tries, phase, dup_err, win, lose} !== 68'h0)
            $display("FAIL win_restart: outputs=%h required 0",
                     {entry, entry_cnt, secret, guess, match_en, last_a, last_b, tries, phase, dup_err, win, lose});
        else n_pass++;
    endtask

    task automatic test_lose();
        type_word(16'h1234);
        for (int i = 0; i < MAX_TRIES; i++) begin
            type_word(16'h5678);
            wait_leave_check();
            if (i < MAX_TRIES - 1) wait_phase(3'd1);
        end
        n_checks++;
        if (phase !== 3'd5 || lose !== 1'b1 || win !== 1'b0 || tries !== 4'(MAX_TRIES) || match_en !== 1'b0)
            $display("FAIL lose_final: phase=%0d lose=%b win=%b tries=%0d en=%b required 5/1/0/%0d/0",
                     phase, lose, win, tries, match_en, MAX_TRIES);
        else n_pass++;
        step(1'b1, 4'd3);
        n_checks++;
        if (phase !== 3'd5 || entry !== 16'h0 || guess !== 16'h5678)
            $display("FAIL lose_terminal: phase=%0d entry=%h guess=%h required 5/0000/5678", phase, entry, guess);
        else n_pass++;
    endtask

    task automatic test_rst_in_check();
        step(1'b1, 4'd12);
        type_word(16'h1234);
        type_word(16'h1243);
        n_checks++;
        if (phase !== 3'd2 || match_en !== 1'b1) $display("FAIL enter_check: phase=%0d en=%b required 2/1", phase, match_en);
        else n_pass++;
        #2 rst = 1;
        #1;
        n_checks++;
        if ({entry, entry_cnt, secret, guess, match_en, last_a, last_b, tries, phase, dup_err, win, lose} !== 68'h0)
            $display("FAIL rst_in_check: outputs=%h required 0",
                     {entry, entry_cnt, secret, guess, match_en, last_a, last_b, tries, phase, dup_err, win, lose});
        else n_pass++;
        @(negedge clk);
        key_valid = 0;
        rst = 0;
        m_reset();
    endtask

    task automatic test_restart_in_check();
        type_word(16'h1234);
        type_word(16'h5678);
        wait_leave_check();
        wait_phase(3'd1);
        type_word(16'h1243);
        step(1'b0, 4'd0);
        step(1'b1, 4'd12);
        n_checks++;
        if (phase !== 3'd0 || tries !== 4'd0 || match_en !== 1'b0 || guess !== 16'h0 || last_a !== 3'd0)
            $display("FAIL restart_in_check: phase=%0d tries=%0d en=%b guess=%h a=%0d required 0/0/0/0000/0",
                     phase, tries, match_en, guess, last_a);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [67:0] got, exp;
        int r;
        logic [3:0] kc;
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      kc = 4'($urandom_range(0, 9));
            else if (r < 78) kc = 4'd10;
            else if (r < 92) kc = 4'd11;
            else if (r < 94) kc = 4'd12;
            else             kc = 4'($urandom_range(13, 15));
            step(($urandom_range(0, 9) < 7), kc);
            got = {entry, entry_cnt, secret, guess, match_en, last_a, last_b, tries, phase, dup_err, win, lose};
            exp = {m_entry(), 3'(m_q.size()), m_secret, m_guess, (m_phase == 2), 3'(m_a), 3'(m_b),
                   4'(m_tries), 3'(m_phase), m_dup, (m_phase == 4), (m_phase == 5)};
            n_checks++;
            if (got !== exp) $display("FAIL random_step%0d: outputs=%h required %h", n, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_secret();
        test_edit();
        test_check();
        test_win();
        test_lose();
        test_rst_in_check();
        test_restart_in_check();
        step(1'b1, 4'd12);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
- Round sequencer for the number-guessing game. It runs the game flow from keypad input to win/lose.
- Phases: collect a 4-digit secret, collect 4-digit guesses, trigger and sample the A/B matcher, hold the result for display, count attempts, declare win or lose.
- Sits between the keypad scanner (decoded key strobe) and the matcher/seven-segment/dot-matrix blocks. It owns the secret, guess and entry registers that feed them.

Parameters:
MAX_TRIES, 10, attempts allowed before LOSE (1..15)
MATCH_LAT, 0, matcher latency in clk cycles (0 = combinational)
RESULT_HOLD, 16, clk cycles RESULT phase is held before returning to GUESS (>=1)

Ports:
clk  in  1  system clock (divided keypad clock domain)
rst  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit, 10 enter, 11 backspace, 12 restart, 13-15 ignored
r_a  in  3  matcher A count (right digit, right place)
r_b  in  3  matcher B count (right digit, wrong place)
entry  out  16  digits being typed, 4 BCD nibbles, newest in [3:0]
entry_cnt  out  3  digits currently in entry (0..4)
secret  out  16  committed secret, to matcher
guess  out  16  committed guess, to matcher
match_en  out  1  high for the whole CHECK phase
last_a  out  3  sampled r_a of latest guess
last_b  out  3  sampled r_b of latest guess
tries  out  4  completed attempts
phase  out  3  0 SET_SECRET, 1 GUESS, 2 CHECK, 3 RESULT, 4 WIN, 5 LOSE
dup_err  out  1  one-cycle pulse on a rejected duplicate digit
win  out  1  equals (phase==WIN)
lose  out  1  equals (phase==LOSE)

Behaviour:
- Reset (async, rst=1): every output and internal register is 0, phase=SET_SECRET, hold counter is 0. Registers update on the rising clk edge only.
- Keys act only when key_valid=1. Codes 13-15 are ignored everywhere.
- Restart (12) in any phase: next cycle phase=SET_SECRET. Entry, secret, guess, tries, last_a and last_b are cleared. Aborts CHECK with no tries increment.
- Entry editing (SET_SECRET and GUESS only):
  - Digit, entry_cnt<4, not already in the valid nibbles: entry<={entry[11:0],digit}, entry_cnt+1.
  - Digit already present: entry unchanged, dup_err=1 the next cycle.
  - Digit with entry_cnt==4: ignored, no dup_err.
  - Backspace with entry_cnt>0: entry<={4'h0,entry[15:4]}, entry_cnt-1. Backspace with entry_cnt==0: ignored.
  - Enter with entry_cnt<4: ignored.
- SET_SECRET + enter with entry_cnt==4: secret<=entry, entry and entry_cnt cleared, phase->GUESS.
- GUESS + enter with entry_cnt==4: guess<=entry, entry and entry_cnt cleared, phase->CHECK.
- CHECK:
  - Lasts exactly MATCH_LAT+1 cycles; match_en=1 throughout.
  - On the last CHECK cycle: last_a<=r_a, last_b<=r_b, tries<=tries+1.
  - Next phase: WIN if r_a==4; else LOSE if tries+1==MAX_TRIES; else RESULT.
  - WIN takes priority over LOSE on the final attempt.
  - Keys other than restart are ignored.
- RESULT: hold counter counts RESULT_HOLD cycles, then phase->GUESS. Digit, enter and backspace are ignored. guess, last_a and last_b stay stable.
- WIN/LOSE: terminal until restart or rst. All registers hold; guess and last_a/last_b remain displayable.
- tries never exceeds MAX_TRIES. It saturates by construction because LOSE is entered first.
- match_en is low in every phase except CHECK.
- dup_err is 0 except for its one-cycle pulse.

Test Plan:
- Reset then enter secret 1,2,3,4 + enter -> secret=16'h1234, phase=GUESS, entry=0, entry_cnt=0, tries=0.
- In GUESS type 5,6,5 -> entry=16'h0056, entry_cnt=2, dup_err pulses one cycle on the second 5. Backspace -> entry=16'h0005, entry_cnt=1. Enter -> ignored, phase stays GUESS.
- Secret 1234, guess 1243, matcher driving r_a=2, r_b=2, MATCH_LAT=2 -> match_en high exactly 3 cycles, last_a=2, last_b=2, tries=1, phase RESULT for 16 cycles, then GUESS.
- Guess 1234 on attempt 3 with r_a=4 -> phase=WIN, win=1, tries=3. Further digits and enter are ignored. Restart -> SET_SECRET with all registers 0.
- MAX_TRIES=2, two wrong guesses (r_a=0) -> phase=LOSE after the 2nd CHECK, tries=2. Also: final guess with r_a=4 on attempt 2 -> WIN, not LOSE.
- Assert rst during CHECK -> all outputs 0 immediately, before any clk edge; phase=SET_SECRET. Restart key during CHECK -> SET_SECRET next cycle, tries not incremented.
